// File: rtl/keycode_pkg.sv
// keycode_pkg
// Shared keycode constants, the pacer state encoding and the letter decode
// helpers. Imported by keycode_pacer and by the cursor/highlight logic so both
// agree on which HID usage codes mean what.
package keycode_pkg;

  // HID usage codes of interest
  localparam logic [7:0] KEY_NONE = 8'h00;
  localparam logic [7:0] KEY_A    = 8'h04;
  localparam logic [7:0] KEY_D    = 8'h07;
  localparam logic [7:0] KEY_S    = 8'h16;
  localparam logic [7:0] KEY_W    = 8'h1A;
  localparam logic [7:0] KEY_Z    = 8'h1D;
  localparam logic [7:0] KEY_BKSP = 8'h2A;

  // ASCII base for uppercase letters
  localparam logic [7:0] ASCII_A  = 8'h41;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } pacer_state_t;

  // True when the usage code is one of the 26 letter keys A..Z.
  function automatic logic is_letter(input logic [7:0] code);
    return (code >= KEY_A) && (code <= KEY_Z);
  endfunction

  // Uppercase ASCII for a letter key, KEY_NONE for anything else.
  // Letter usage codes are contiguous, so an 8-bit offset from KEY_A maps
  // straight onto 'A'..'Z'.
  function automatic logic [7:0] letter_of(input logic [7:0] code);
    return is_letter(code) ? (ASCII_A + (code - KEY_A)) : KEY_NONE;
  endfunction

endpackage

// File: rtl/keycode_pacer.sv
// keycode_pacer
// Turns the level-style keycode from the USB keyboard host into discrete,
// frame-paced key events: one event on press, then typematic repeats after
// DELAY_FRAMES, spaced REPEAT_FRAMES apart. A different non-zero code while a
// key is held is a fresh press (rollover wins over repeat).
//
// Ports:
//   frame_clk    in   frame clock (vertical sync rate)
//   Reset        in   asynchronous, active-high reset
//   raw_keycode  in   [7:0] HID usage code, 8'h00 = no key
//   keycode      out  [7:0] event code for one frame per event, else 8'h00
//   key_event    out  one-frame pulse with a non-zero keycode
//   letter_valid out  event is a letter key (8'h04..8'h1D)
//   letter       out  [7:0] uppercase ASCII of a letter event, else 8'h00
//   erase        out  one-frame pulse on a Backspace event
module keycode_pacer
  import keycode_pkg::*;
#(
  parameter int DELAY_FRAMES  = 20,
  parameter int REPEAT_FRAMES = 4
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] raw_keycode,
  output logic [7:0] keycode,
  output logic       key_event,
  output logic       letter_valid,
  output logic [7:0] letter,
  output logic       erase
);

  localparam int MAX_FRAMES = (DELAY_FRAMES > REPEAT_FRAMES) ? DELAY_FRAMES : REPEAT_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES) + 1;

  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(DELAY_FRAMES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  pacer_state_t     state_q, state_d;
  logic [7:0]       raw_q;
  logic [7:0]       held_q, held_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             emit_s;
  logic [7:0]       emit_code_s;

  logic [7:0]       keycode_q, keycode_d;
  logic             key_event_q, key_event_d;
  logic             letter_valid_q, letter_valid_d;
  logic [7:0]       letter_q, letter_d;
  logic             erase_q, erase_d;

  // Next-state and event decision from the captured keycode
  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    cnt_d       = cnt_q;
    emit_s      = 1'b0;
    emit_code_s = KEY_NONE;

    case (state_q)
      IDLE: begin
        if (raw_q != KEY_NONE) begin
          held_d      = raw_q;
          cnt_d       = DELAY_LOAD;
          state_d     = DELAY;
          emit_s      = 1'b1;
          emit_code_s = raw_q;
        end else begin
          state_d = IDLE;
        end
      end

      DELAY, REPEAT: begin
        if (raw_q == KEY_NONE) begin
          // Release is silent
          state_d = IDLE;
        end else if (raw_q != held_q) begin
          // Rollover to another key restarts the press sequence
          held_d      = raw_q;
          cnt_d       = DELAY_LOAD;
          state_d     = DELAY;
          emit_s      = 1'b1;
          emit_code_s = raw_q;
        end else if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          cnt_d       = REPEAT_LOAD;
          state_d     = REPEAT;
          emit_s      = 1'b1;
          emit_code_s = held_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Event output decode; emit_code_s is KEY_NONE on quiet frames
  always_comb begin
    if (emit_s) begin
      keycode_d      = emit_code_s;
      key_event_d    = 1'b1;
      letter_valid_d = is_letter(emit_code_s);
      letter_d       = letter_of(emit_code_s);
      erase_d        = (emit_code_s == KEY_BKSP);
    end else begin
      keycode_d      = KEY_NONE;
      key_event_d    = 1'b0;
      letter_valid_d = 1'b0;
      letter_d       = KEY_NONE;
      erase_d        = 1'b0;
    end
  end

  // Capture stage, FSM state and registered outputs
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      raw_q          <= KEY_NONE;
      held_q         <= KEY_NONE;
      cnt_q          <= CNT_ZERO;
      state_q        <= IDLE;
      keycode_q      <= KEY_NONE;
      key_event_q    <= 1'b0;
      letter_valid_q <= 1'b0;
      letter_q       <= KEY_NONE;
      erase_q        <= 1'b0;
    end else begin
      raw_q          <= raw_keycode;
      held_q         <= held_d;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      keycode_q      <= keycode_d;
      key_event_q    <= key_event_d;
      letter_valid_q <= letter_valid_d;
      letter_q       <= letter_d;
      erase_q        <= erase_d;
    end
  end

  assign keycode      = keycode_q;
  assign key_event    = key_event_q;
  assign letter_valid = letter_valid_q;
  assign letter       = letter_q;
  assign erase        = erase_q;

endmodule
